issue_unit: RTL and testbench

- Issue stage of the out-of-order core. It sits between the Decoder and the RS/LSB/RoB, and is the producer side of the RS issue interface.
- Holds the architectural register file and the register-status (rename tag) table.
- Resolves each operand to a value or a RoB dependency tag, with forwarding from the ALU/LSB broadcast buses, RoB lookup and commit.
- Emits one registered issue packet per accepted instruction, and stalls the Decoder on backpressure.

---
 rtl/issue_unit.sv | 207 ++++++++++++++++++++
 tb/tb_issue_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_unit.sv
// Issue stage of the out-of-order core. Holds the architectural register
// file and the rename tag table, resolves each operand to a value or a RoB
// dependency tag, and emits one registered issue packet per accepted
// instruction to the RS, LSB and RoB.
module issue_unit #(
  parameter int ROB_W = 4,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [31:0]      dec_instr,
  input  logic [31:0]      dec_addr,
  input  logic [2:0]       dec_op,
  input  logic [6:0]       dec_type,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic [4:0]       dec_rd,
  input  logic             dec_use1,
  input  logic             dec_use2,
  input  logic             dec_wr_rd,
  input  logic             dec_to_rs,
  input  logic             dec_to_lsb,
  input  logic             rs_full,
  input  logic             lsb_full,
  input  logic             rob_full,
  input  logic [ROB_W-1:0] rob_tail_id,
  output logic [ROB_W-1:0] rob_q1_id,
  output logic [ROB_W-1:0] rob_q2_id,
  input  logic             rob_q1_ready,
  input  logic             rob_q2_ready,
  input  logic [31:0]      rob_q1_value,
  input  logic [31:0]      rob_q2_value,
  input  logic             alu_ready,
  input  logic [ROB_W-1:0] alu_rob_id,
  input  logic [31:0]      alu_value,
  input  logic             lsb_ready,
  input  logic [ROB_W-1:0] lsb_rob_id,
  input  logic [31:0]      lsb_value,
  input  logic             commit_valid,
  input  logic [4:0]       commit_rd,
  input  logic [ROB_W-1:0] commit_rob_id,
  input  logic [31:0]      commit_value,
  input  logic             rob_clear,
  output logic             instr_issued,
  output logic             iss_to_rs,
  output logic             iss_to_lsb,
  output logic [31:0]      iss_instr,
  output logic [31:0]      iss_addr,
  output logic [2:0]       iss_op,
  output logic [6:0]       iss_type,
  output logic [4:0]       iss_rd,
  output logic [31:0]      reg_value1,
  output logic [31:0]      reg_value2,
  output logic             has_dep1,
  output logic             has_dep2,
  output logic [ROB_W-1:0] v_rob_id1,
  output logic [ROB_W-1:0] v_rob_id2,
  output logic [ROB_W-1:0] rd_rob_id
);

  typedef struct packed {
    logic [31:0]      value;
    logic             dep;
    logic [ROB_W-1:0] id;
  } opnd_t;

  // Architectural state: register file and rename tag table.
  logic [31:0]      r_regfile   [NREG];
  logic [ROB_W-1:0] r_tag       [NREG];
  logic             r_tag_valid [NREG];

  // Registered issue packet.
  logic             r_issued;
  logic             r_to_rs, r_to_lsb;
  logic [31:0]      r_instr, r_addr;
  logic [2:0]       r_op;
  logic [6:0]       r_type;
  logic [4:0]       r_rd;
  opnd_t            r_op1, r_op2;
  logic [ROB_W-1:0] r_rd_rob_id;

  logic  w_stall, w_accept, w_retag, w_commit_wr, w_commit_clr;
  opnd_t w_op1, w_op2;

  // Resolve one operand against the pre-update tables, newest source first.
  function automatic opnd_t resolve(input logic use_k, input logic [4:0] rs,
                                    input logic q_ready, input logic [31:0] q_value);
    opnd_t            o;
    logic [ROB_W-1:0] t;
    o = '0;
    t = r_tag[rs];
    if (!use_k || rs == 5'd0) begin
      o = '0;
    end else if (r_tag_valid[rs]) begin
      if (commit_valid && commit_rob_id == t)   o.value = commit_value;
      else if (alu_ready && alu_rob_id == t)    o.value = alu_value;
      else if (lsb_ready && lsb_rob_id == t)    o.value = lsb_value;
      else if (q_ready)                         o.value = q_value;
      else begin
        o.dep = 1'b1;
        o.id  = t;
      end
    end else if (commit_valid && commit_rd == rs) begin
      o.value = commit_value;
    end else begin
      o.value = r_regfile[rs];
    end
    return o;
  endfunction

  // Handshake: stall on any full target, flush or global disable.
  always_comb begin
    w_stall      = rob_full | (dec_to_rs & rs_full) | (dec_to_lsb & lsb_full)
                 | rob_clear | ~rdy;
    dec_ready    = rst_n & ~w_stall;
    w_accept     = dec_valid & dec_ready;
    w_retag      = w_accept & dec_wr_rd & (dec_rd != 5'd0);
    w_commit_wr  = commit_valid & (commit_rd != 5'd0);
    // A same-cycle issue that retags the register keeps its new tag.
    w_commit_clr = w_commit_wr & r_tag_valid[commit_rd]
                 & (r_tag[commit_rd] == commit_rob_id)
                 & ~(w_retag & (dec_rd == commit_rd));
  end

  // Operand resolution and RoB lookup ids.
  always_comb begin
    w_op1     = resolve(dec_use1, dec_rs1, rob_q1_ready, rob_q1_value);
    w_op2     = resolve(dec_use2, dec_rs2, rob_q2_ready, rob_q2_value);
    rob_q1_id = r_tag[dec_rs1];
    rob_q2_id = r_tag[dec_rs2];
  end

  // Register file and tag table update: commit writes, issue retags, flush clears tags.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the tables are small flop arrays that must read as zero after
    // reset, so they are reset explicitly rather than inferred as a RAM.
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regfile[i]   <= '0;
        r_tag[i]       <= '0;
        r_tag_valid[i] <= 1'b0;
      end
    end else if (rdy) begin
      // NOTE: non-blocking assignments so every read above sees pre-edge state.
      if (w_commit_wr)  r_regfile[commit_rd]   <= commit_value;
      if (w_commit_clr) r_tag_valid[commit_rd] <= 1'b0;
      if (w_retag) begin
        r_tag[dec_rd]       <= rob_tail_id;
        r_tag_valid[dec_rd] <= 1'b1;
      end
      if (rob_clear) begin
        for (int i = 0; i < NREG; i++) r_tag_valid[i] <= 1'b0;
      end
    end
  end

  // Issue packet register: one-cycle pulse, payload holds between issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued    <= 1'b0;
      r_to_rs     <= 1'b0;
      r_to_lsb    <= 1'b0;
      r_instr     <= '0;
      r_addr      <= '0;
      r_op        <= '0;
      r_type      <= '0;
      r_rd        <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_rd_rob_id <= '0;
    end else begin
      r_issued <= w_accept;
      if (w_accept) begin
        r_to_rs     <= dec_to_rs;
        r_to_lsb    <= dec_to_lsb;
        r_instr     <= dec_instr;
        r_addr      <= dec_addr;
        r_op        <= dec_op;
        r_type      <= dec_type;
        r_rd        <= dec_rd;
        r_op1       <= w_op1;
        r_op2       <= w_op2;
        r_rd_rob_id <= rob_tail_id;
      end
    end
  end

  assign instr_issued = r_issued;
  assign iss_to_rs    = r_to_rs;
  assign iss_to_lsb   = r_to_lsb;
  assign iss_instr    = r_instr;
  assign iss_addr     = r_addr;
  assign iss_op       = r_op;
  assign iss_type     = r_type;
  assign iss_rd       = r_rd;
  assign reg_value1   = r_op1.value;
  assign reg_value2   = r_op2.value;
  assign has_dep1     = r_op1.dep;
  assign has_dep2     = r_op2.dep;
  assign v_rob_id1    = r_op1.id;
  assign v_rob_id2    = r_op2.id;
  assign rd_rob_id    = r_rd_rob_id;

endmodule

// File: tb/tb_issue_unit.sv
// Self-checking bench for issue_unit: directed scenarios followed by random
// traffic, compared against a behavioural model of the register file,
// rename table and issue packet.
module tb_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n, rdy, dec_valid, dec_ready;
  logic [31:0] dec_instr, dec_addr;
  logic [2:0]  dec_op;
  logic [6:0]  dec_type;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_use1, dec_use2, dec_wr_rd, dec_to_rs, dec_to_lsb;
  logic        rs_full, lsb_full, rob_full;
  logic [3:0]  rob_tail_id, rob_q1_id, rob_q2_id;
  logic        rob_q1_ready, rob_q2_ready;
  logic [31:0] rob_q1_value, rob_q2_value;
  logic        alu_ready, lsb_ready;
  logic [3:0]  alu_rob_id, lsb_rob_id;
  logic [31:0] alu_value, lsb_value;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [3:0]  commit_rob_id;
  logic [31:0] commit_value;
  logic        rob_clear;
  logic        instr_issued, iss_to_rs, iss_to_lsb;
  logic [31:0] iss_instr, iss_addr;
  logic [2:0]  iss_op;
  logic [6:0]  iss_type;
  logic [4:0]  iss_rd;
  logic [31:0] reg_value1, reg_value2;
  logic        has_dep1, has_dep2;
  logic [3:0]  v_rob_id1, v_rob_id2, rd_rob_id;

  issue_unit #(.ROB_W(4), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_addr(dec_addr), .dec_op(dec_op), .dec_type(dec_type),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_wr_rd(dec_wr_rd),
    .dec_to_rs(dec_to_rs), .dec_to_lsb(dec_to_lsb),
    .rs_full(rs_full), .lsb_full(lsb_full), .rob_full(rob_full), .rob_tail_id(rob_tail_id),
    .rob_q1_id(rob_q1_id), .rob_q2_id(rob_q2_id),
    .rob_q1_ready(rob_q1_ready), .rob_q2_ready(rob_q2_ready),
    .rob_q1_value(rob_q1_value), .rob_q2_value(rob_q2_value),
    .alu_ready(alu_ready), .alu_rob_id(alu_rob_id), .alu_value(alu_value),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_rob_id(commit_rob_id),
    .commit_value(commit_value), .rob_clear(rob_clear),
    .instr_issued(instr_issued), .iss_to_rs(iss_to_rs), .iss_to_lsb(iss_to_lsb),
    .iss_instr(iss_instr), .iss_addr(iss_addr), .iss_op(iss_op), .iss_type(iss_type),
    .iss_rd(iss_rd), .reg_value1(reg_value1), .reg_value2(reg_value2),
    .has_dep1(has_dep1), .has_dep2(has_dep2), .v_rob_id1(v_rob_id1), .v_rob_id2(v_rob_id2),
    .rd_rob_id(rd_rob_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural model: architectural state plus the last issued packet.
  logic [31:0] m_reg [32];
  logic [3:0]  m_tag [32];
  bit          m_tv  [32];
  bit          p_issued, p_to_rs, p_to_lsb, p_dep1, p_dep2;
  logic [31:0] p_instr, p_addr, p_val1, p_val2;
  logic [2:0]  p_op;
  logic [6:0]  p_type;
  logic [4:0]  p_rd;
  logic [3:0]  p_id1, p_id2, p_rd_id;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0; m_tag[i] = '0; m_tv[i] = 1'b0;
    end
    p_issued = 0; p_to_rs = 0; p_to_lsb = 0; p_dep1 = 0; p_dep2 = 0;
    p_instr = '0; p_addr = '0; p_val1 = '0; p_val2 = '0;
    p_op = '0; p_type = '0; p_rd = '0; p_id1 = '0; p_id2 = '0; p_rd_id = '0;
  endtask

  // Where does operand k's value come from at this accept?
  task automatic model_operand(input bit use_k, input logic [4:0] rs, input bit q_ready,
                               input logic [31:0] q_value, output logic [31:0] val,
                               output bit dep, output logic [3:0] id);
    val = '0; dep = 0; id = '0;
    if (use_k && rs != 0) begin
      if (m_tv[rs]) begin
        if (commit_valid && commit_rob_id == m_tag[rs])   val = commit_value;
        else if (alu_ready && alu_rob_id == m_tag[rs])    val = alu_value;
        else if (lsb_ready && lsb_rob_id == m_tag[rs])    val = lsb_value;
        else if (q_ready)                                 val = q_value;
        else begin dep = 1; id = m_tag[rs]; end
      end else if (commit_valid && commit_rd == rs) begin
        val = commit_value;
      end else begin
        val = m_reg[rs];
      end
    end
  endtask

  task automatic check_pkt(input string ctx);
    check({ctx, ".instr_issued"}, 32'(instr_issued), 32'(p_issued));
    check({ctx, ".iss_to_rs"},    32'(iss_to_rs),    32'(p_to_rs));
    check({ctx, ".iss_to_lsb"},   32'(iss_to_lsb),   32'(p_to_lsb));
    check({ctx, ".iss_instr"},    iss_instr,         p_instr);
    check({ctx, ".iss_addr"},     iss_addr,          p_addr);
    check({ctx, ".iss_op"},       32'(iss_op),       32'(p_op));
    check({ctx, ".iss_type"},     32'(iss_type),     32'(p_type));
    check({ctx, ".iss_rd"},       32'(iss_rd),       32'(p_rd));
    check({ctx, ".reg_value1"},   reg_value1,        p_val1);
    check({ctx, ".reg_value2"},   reg_value2,        p_val2);
    check({ctx, ".has_dep1"},     32'(has_dep1),     32'(p_dep1));
    check({ctx, ".has_dep2"},     32'(has_dep2),     32'(p_dep2));
    check({ctx, ".v_rob_id1"},    32'(v_rob_id1),    32'(p_id1));
    check({ctx, ".v_rob_id2"},    32'(v_rob_id2),    32'(p_id2));
    check({ctx, ".rd_rob_id"},    32'(rd_rob_id),    32'(p_rd_id));
  endtask

  task automatic idle();
    rdy = 1; dec_valid = 0; dec_instr = '0; dec_addr = '0; dec_op = '0; dec_type = '0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0; dec_use1 = 0; dec_use2 = 0; dec_wr_rd = 0;
    dec_to_rs = 0; dec_to_lsb = 0; rs_full = 0; lsb_full = 0; rob_full = 0;
    rob_tail_id = '0; rob_q1_ready = 0; rob_q2_ready = 0; rob_q1_value = '0; rob_q2_value = '0;
    alu_ready = 0; alu_rob_id = '0; alu_value = '0; lsb_ready = 0; lsb_rob_id = '0;
    lsb_value = '0; commit_valid = 0; commit_rd = '0; commit_rob_id = '0; commit_value = '0;
    rob_clear = 0;
  endtask

  // One cycle: inputs were driven at the falling edge; check the handshake,
  // predict the packet, advance the model, then compare after the rising edge.
  task automatic step(input string ctx);
    bit exp_ready, acc;
    #1;
    exp_ready = rst_n && !(rob_full || (dec_to_rs && rs_full) || (dec_to_lsb && lsb_full)
                           || rob_clear || !rdy);
    check({ctx, ".dec_ready"}, 32'(dec_ready), 32'(exp_ready));
    if (m_tv[dec_rs1] && dec_use1 && dec_rs1 != 0)
      check({ctx, ".rob_q1_id"}, 32'(rob_q1_id), 32'(m_tag[dec_rs1]));
    if (m_tv[dec_rs2] && dec_use2 && dec_rs2 != 0)
      check({ctx, ".rob_q2_id"}, 32'(rob_q2_id), 32'(m_tag[dec_rs2]));
    acc = dec_valid && exp_ready;
    p_issued = acc;
    if (acc) begin
      p_to_rs = dec_to_rs; p_to_lsb = dec_to_lsb; p_instr = dec_instr; p_addr = dec_addr;
      p_op = dec_op; p_type = dec_type; p_rd = dec_rd; p_rd_id = rob_tail_id;
      model_operand(dec_use1, dec_rs1, rob_q1_ready, rob_q1_value, p_val1, p_dep1, p_id1);
      model_operand(dec_use2, dec_rs2, rob_q2_ready, rob_q2_value, p_val2, p_dep2, p_id2);
    end
    if (rdy) begin
      if (commit_valid && commit_rd != 0) begin
        m_reg[commit_rd] = commit_value;
        if (m_tv[commit_rd] && m_tag[commit_rd] == commit_rob_id) m_tv[commit_rd] = 0;
      end
      if (acc && dec_wr_rd && dec_rd != 0) begin
        m_tag[dec_rd] = rob_tail_id; m_tv[dec_rd] = 1;
      end
      if (rob_clear) for (int i = 0; i < 32; i++) m_tv[i] = 0;
    end
    @(posedge clk); #1;
    check_pkt(ctx);
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [3:0] tail);
    dec_valid = 1; dec_to_rs = 1; dec_instr = $urandom; dec_addr = $urandom;
    dec_op = 3'($urandom); dec_type = 7'($urandom);
    dec_rd = rd; dec_wr_rd = (rd != 0); dec_rs1 = rs1; dec_use1 = 1;
    dec_rs2 = rs2; dec_use2 = 1; rob_tail_id = tail;
  endtask

  task automatic rand_inputs();
    int sel;
    idle();
    rdy        = ($urandom_range(0, 19) != 0);
    dec_valid  = ($urandom_range(0, 4) != 0);
    dec_instr  = $urandom; dec_addr = $urandom;
    dec_op     = 3'($urandom); dec_type = 7'($urandom);
    dec_rs1    = 5'($urandom_range(0, 7)); dec_rs2 = 5'($urandom_range(0, 7));
    dec_rd     = 5'($urandom_range(0, 7));
    dec_use1   = $urandom_range(0, 1); dec_use2 = $urandom_range(0, 1);
    dec_wr_rd  = $urandom_range(0, 1);
    sel        = $urandom_range(0, 2);
    dec_to_rs  = (sel == 0); dec_to_lsb = (sel == 1);
    rs_full    = ($urandom_range(0, 4) == 0); lsb_full = ($urandom_range(0, 4) == 0);
    rob_full   = ($urandom_range(0, 9) == 0);
    rob_tail_id  = 4'($urandom_range(0, 7));
    rob_q1_ready = ($urandom_range(0, 2) == 0); rob_q1_value = $urandom;
    rob_q2_ready = ($urandom_range(0, 2) == 0); rob_q2_value = $urandom;
    alu_ready  = ($urandom_range(0, 2) == 0); alu_rob_id = 4'($urandom_range(0, 7));
    alu_value  = $urandom;
    lsb_ready  = ($urandom_range(0, 2) == 0); lsb_rob_id = 4'($urandom_range(0, 7));
    lsb_value  = $urandom;
    commit_valid  = ($urandom_range(0, 4) < 2); commit_rd = 5'($urandom_range(0, 7));
    commit_rob_id = 4'($urandom_range(0, 7)); commit_value = $urandom;
    rob_clear  = ($urandom_range(0, 24) == 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    idle();
    rst_n = 0;
    #3;
    check("reset.dec_ready", 32'(dec_ready), 32'd0);
    check_pkt("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    step("idle");

    // Producer then back-to-back consumer of x5.
    idle(); issue(5'd5, 5'd0, 5'd0, 4'd3); step("addi_x5");
    check("addi.rd_rob_id", 32'(rd_rob_id), 32'd3);
    check("addi.has_dep1", 32'(has_dep1), 32'd0);
    idle(); issue(5'd6, 5'd5, 5'd0, 4'd4); step("add_rs1_x5");
    check("add.has_dep1", 32'(has_dep1), 32'd1);
    check("add.v_rob_id1", 32'(v_rob_id1), 32'd3);

    // Forwarding from ALU, LSB and RoB lookup.
    idle(); issue(5'd0, 5'd5, 5'd0, 4'd5); alu_ready = 1; alu_rob_id = 4'd3;
    alu_value = 32'h1234; step("fwd_alu");
    check("fwd_alu.reg_value1", reg_value1, 32'h1234);
    check("fwd_alu.v_rob_id1", 32'(v_rob_id1), 32'd0);
    idle(); issue(5'd0, 5'd5, 5'd0, 4'd5); lsb_ready = 1; lsb_rob_id = 4'd3;
    lsb_value = 32'h1234; step("fwd_lsb");
    check("fwd_lsb.reg_value1", reg_value1, 32'h1234);
    idle(); issue(5'd0, 5'd5, 5'd0, 4'd5); rob_q1_ready = 1; rob_q1_value = 32'hBEEF;
    step("fwd_rob");
    check("fwd_rob.reg_value1", reg_value1, 32'hBEEF);
    check("fwd_rob.has_dep1", 32'(has_dep1), 32'd0);

    // Commit of x5 while a same-cycle issue retags it.
    idle(); issue(5'd5, 5'd0, 5'd0, 4'd6); commit_valid = 1; commit_rd = 5'd5;
    commit_rob_id = 4'd3; commit_value = 32'd7; step("commit_retag");
    idle(); issue(5'd0, 5'd5, 5'd0, 4'd7); step("read_after_retag");
    check("retag.has_dep1", 32'(has_dep1), 32'd1);
    check("retag.v_rob_id1", 32'(v_rob_id1), 32'd6);

    // Backpressure.
    idle(); issue(5'd0, 5'd0, 5'd0, 4'd1); rs_full = 1; step("rs_full");
    check("rs_full.instr_issued", 32'(instr_issued), 32'd0);
    idle(); issue(5'd0, 5'd0, 5'd0, 4'd1); dec_to_rs = 0; dec_to_lsb = 1; rs_full = 1;
    step("lsb_target");
    check("lsb_target.instr_issued", 32'(instr_issued), 32'd1);
    idle(); issue(5'd0, 5'd0, 5'd0, 4'd1); rob_full = 1; step("rob_full");
    check("rob_full.instr_issued", 32'(instr_issued), 32'd0);

    // Flush with x1/x2 tagged; same-cycle commit still lands in x1.
    idle(); issue(5'd1, 5'd0, 5'd0, 4'd8); step("tag_x1");
    idle(); issue(5'd2, 5'd0, 5'd0, 4'd9); step("tag_x2");
    idle(); issue(5'd3, 5'd1, 5'd2, 4'd10); rob_clear = 1; commit_valid = 1;
    commit_rd = 5'd1; commit_rob_id = 4'd11; commit_value = 32'h55; step("clear");
    check("clear.instr_issued", 32'(instr_issued), 32'd0);
    idle(); issue(5'd0, 5'd1, 5'd5, 4'd12); step("read_after_clear");
    check("clear.reg_value1", reg_value1, 32'h55);
    check("clear.has_dep1", 32'(has_dep1), 32'd0);
    check("clear.reg_value2", reg_value2, 32'd7);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rand_inputs();
      step("rand");
    end

    // Reset mid-stream with a packet on the outputs.
    idle(); issue(5'd4, 5'd5, 5'd0, 4'd2);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    model_reset();
    check("midreset.dec_ready", 32'(dec_ready), 32'd0);
    check_pkt("midreset");
    @(negedge clk);
    rst_n = 1;
    idle(); issue(5'd0, 5'd5, 5'd4, 4'd1); step("after_reset");
    check("after_reset.has_dep2", 32'(has_dep2), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
